// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: fixed-priority owner of the shared 8-digit seven-segment
// display. Requesters are error (2, highest), viewer (1) and banner (0, lowest).
// A new owner keeps the screen for at least MIN_HOLD cycles. A voluntary
// release is followed by GAP_CYCLES of blank frame.
// Optional feature macro: SEG_ARB_BLINK_EN blinks the error frame while
// requester 2 owns the display.
//
// Handshake: req is a level request and is never acknowledged by a pulse.
// The requester owns the display while its grant bit is high. grant and
// disp_glyphs are registered, so a req sampled at edge N shows up just
// after edge N together with that requester's frame as it was at edge N.
module seg_disp_arbiter #(
  parameter int MIN_HOLD   = 50_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int BLINK_HALF = 25_000_000,
  parameter int CNT_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [39:0] frame0,
  input  logic [39:0] frame1,
  input  logic [39:0] frame2,
  output logic [2:0]  grant,
  output logic [39:0] disp_glyphs,
  output logic        preempt_pulse,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [39:0]      BLANK    = 40'hFF_FFFF_FFFF;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  // Elaborates an empty, named block only when CNT_W is too narrow.
  // The name makes the misconfiguration visible in the elaborated hierarchy.
  if ((64'(MIN_HOLD) >= (64'd1 << CNT_W)) || (64'(GAP_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(BLINK_HALF) >= (64'd1 << CNT_W))) begin : g_cnt_w_too_small
  end

  state_t           state, state_n;
  logic [1:0]       owner, owner_n;
  logic [2:0]       grant_n;
  logic [39:0]      glyph_q, glyph_n;
  logic [CNT_W-1:0] hold_cnt, hold_n, hold_inc;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic             pulse_n;
  logic [1:0]       top_idx;
  logic             any_req, has_higher, own_req;

  // Index of the highest-priority set request bit.
  function automatic logic [1:0] top_of(input logic [2:0] r);
    if (r[2])      top_of = 2'd2;
    else if (r[1]) top_of = 2'd1;
    else           top_of = 2'd0;
  endfunction

  // Frame belonging to a requester index.
  function automatic logic [39:0] frame_of(input logic [1:0] idx,
                                           input logic [39:0] f0,
                                           input logic [39:0] f1,
                                           input logic [39:0] f2);
    case (idx)
      2'd0:    frame_of = f0;
      2'd1:    frame_of = f1;
      2'd2:    frame_of = f2;
      default: frame_of = BLANK;
    endcase
  endfunction

  // Request decode relative to the current owner.
  always_comb begin
    top_idx    = top_of(req);
    any_req    = |req;
    has_higher = 1'b0;
    own_req    = 1'b0;
    case (owner)
      2'd0: begin has_higher = |req[2:1]; own_req = req[0]; end
      2'd1: begin has_higher = req[2];    own_req = req[1]; end
      2'd2: begin has_higher = 1'b0;      own_req = req[2]; end
      default: begin has_higher = 1'b0;   own_req = 1'b0;   end
    endcase
    hold_inc = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
  end

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_n = state;
    owner_n = owner;
    grant_n = grant;
    glyph_n = glyph_q;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    pulse_n = 1'b0;
    case (state)
      ST_IDLE: begin
        glyph_n = BLANK;
        if (any_req) begin
          state_n = ST_OWN;
          owner_n = top_idx;
          grant_n = 3'(3'b001 << top_idx);
          glyph_n = frame_of(top_idx, frame0, frame1, frame2);
          hold_n  = '0;
        end
      end
      ST_OWN, ST_HOLD: begin
        if (has_higher) begin
          // Preemption wins over any simultaneous drop by the owner.
          state_n = ST_OWN;
          owner_n = top_idx;
          grant_n = 3'(3'b001 << top_idx);
          glyph_n = frame_of(top_idx, frame0, frame1, frame2);
          hold_n  = '0;
          pulse_n = 1'b1;
        end else if (own_req) begin
          // Re-assertion from HOLD keeps the running hold count.
          state_n = ST_OWN;
          glyph_n = frame_of(owner, frame0, frame1, frame2);
          hold_n  = hold_inc;
        end else if (hold_cnt >= HOLD_MAX) begin
          state_n = ST_GAP;
          grant_n = 3'b000;
          glyph_n = BLANK;
          gap_n   = '0;
        end else begin
          // Owner released early: freeze the last frame until MIN_HOLD.
          state_n = ST_HOLD;
          hold_n  = hold_inc;
        end
      end
      ST_GAP: begin
        glyph_n = BLANK;
        if (gap_cnt >= GAP_LAST) begin
          if (any_req) begin
            state_n = ST_OWN;
            owner_n = top_idx;
            grant_n = 3'(3'b001 << top_idx);
            glyph_n = frame_of(top_idx, frame0, frame1, frame2);
            hold_n  = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = 3'b000;
        glyph_n = BLANK;
      end
    endcase
  end

  // State, owner, counters and latched frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= 2'd0;
      grant         <= 3'b000;
      glyph_q       <= BLANK;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      preempt_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      grant         <= grant_n;
      glyph_q       <= glyph_n;
      hold_cnt      <= hold_n;
      gap_cnt       <= gap_n;
      preempt_pulse <= pulse_n;
    end
  end

  assign dbg_state = state;

`ifdef SEG_ARB_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;

  // Blink phase: starts "on" at each new grant to requester 2 and toggles
  // every BLINK_HALF cycles while requester 2 holds the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (grant_n[2] && !grant[2]) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (grant[2]) begin
      if (blink_cnt >= BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end
  end

  assign disp_glyphs = (grant[2] && !blink_on) ? BLANK : glyph_q;
`else
  assign disp_glyphs = glyph_q;
`endif

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter with MIN_HOLD=8, GAP_CYCLES=4, BLINK_HALF=3.
module tb_seg_disp_arbiter;

  localparam int MIN_HOLD   = 8;
  localparam int GAP_CYCLES = 4;
  localparam int BLINK_HALF = 3;
`ifdef SEG_ARB_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [39:0] BL  = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] F0  = 40'h01234_56789;
  localparam logic [39:0] F0B = 40'h13579_BDF02;
  localparam logic [39:0] F1  = 40'h0A5A5_5A5A5;
  localparam logic [39:0] F1B = 40'h42108_84210;
  localparam logic [39:0] F2  = 40'h2468A_CE024;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [39:0] frame0, frame1, frame2;
  logic [2:0]  grant;
  logic [39:0] disp_glyphs;
  logic        preempt_pulse;
  logic [1:0]  dbg_state;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [39:0] f0;
    logic [39:0] f1;
    logic [39:0] f2;
    logic [2:0]  eg;
    logic        ep;
    logic [39:0] egl;
  } vec_t;

  vec_t        vecs[$];
  logic [43:0] exp_q[$];
  logic [39:0] cf0, cf1, cf2;
  int          n_tests = 0;
  int          n_fail  = 0;

  seg_disp_arbiter #(
    .MIN_HOLD  (MIN_HOLD),
    .GAP_CYCLES(GAP_CYCLES),
    .BLINK_HALF(BLINK_HALF),
    .CNT_W     (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .frame0       (frame0),
    .frame1       (frame1),
    .frame2       (frame2),
    .grant        (grant),
    .disp_glyphs  (disp_glyphs),
    .preempt_pulse(preempt_pulse),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [43:0] exp);
    logic [43:0] act;
    act = {grant, preempt_pulse, disp_glyphs};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b pulse=%b glyphs=%h, expected grant=%b pulse=%b glyphs=%h",
               name, act[43:41], act[40], act[39:0], exp[43:41], exp[40], exp[39:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver: one cycle of stimulus with its expected post-edge outputs queued.
  task automatic drive(input logic r, input logic [2:0] rq, input logic [39:0] f0,
                       input logic [39:0] f1, input logic [39:0] f2, input logic [43:0] e);
    rst = r; req = rq; frame0 = f0; frame1 = f1; frame2 = f2;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare the oldest expectation after the active edge.
  task automatic score(input string name);
    logic [43:0] e;
    tick();
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty, expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check_out(name, e);
    end
  endtask

  task automatic add_v(input logic r, input logic [2:0] rq, input logic [2:0] eg,
                       input logic ep, input logic [39:0] egl);
    vec_t x;
    x.rst = r; x.req = rq; x.f0 = cf0; x.f1 = cf1; x.f2 = cf2;
    x.eg = eg; x.ep = ep; x.egl = egl;
    vecs.push_back(x);
  endtask

  initial begin
    int          cnt;
    int          gap_len;
    logic [63:0] rnd;
    logic [39:0] exp_gl;

    rst = 1'b1; req = 3'b000; frame0 = F0; frame1 = F1; frame2 = F2;
    cf0 = F0; cf1 = F1; cf2 = F2;

    // Reset, first grant, frame follow, preemption at hold_cnt = 2.
    add_v(1, 3'b000, 3'b000, 0, BL);
    add_v(1, 3'b001, 3'b000, 0, BL);
    add_v(0, 3'b001, 3'b001, 0, F0);
    cf0 = F0B;
    add_v(0, 3'b001, 3'b001, 0, F0B);
    add_v(0, 3'b001, 3'b001, 0, F0B);
    add_v(0, 3'b011, 3'b010, 1, F1);
    // Lower request waits; owner 1 drops 3 cycles after grant.
    add_v(0, 3'b011, 3'b010, 0, F1);
    add_v(0, 3'b010, 3'b010, 0, F1);
    add_v(0, 3'b010, 3'b010, 0, F1);
    cf1 = F1B;
    add_v(0, 3'b001, 3'b010, 0, F1);
    for (int i = 0; i < 4; i++) add_v(0, 3'b001, 3'b010, 0, F1);
    add_v(0, 3'b001, 3'b000, 0, BL);
    for (int i = 0; i < 3; i++) add_v(0, 3'b001, 3'b000, 0, BL);
    add_v(0, 3'b000, 3'b000, 0, BL);
    // Full hold then gap, with error and banner requesting during the gap.
    add_v(0, 3'b001, 3'b001, 0, F0B);
    for (int i = 0; i < 8; i++) add_v(0, 3'b001, 3'b001, 0, F0B);
    add_v(0, 3'b000, 3'b000, 0, BL);
    for (int i = 0; i < 3; i++) add_v(0, 3'b101, 3'b000, 0, BL);
    add_v(0, 3'b101, 3'b100, 0, F2);
    add_v(0, 3'b100, 3'b100, 0, F2);
    add_v(1, 3'b100, 3'b000, 0, BL);
    // HOLD re-asserted at hold_cnt = 5; gap only once hold_cnt reaches 8.
    add_v(0, 3'b010, 3'b010, 0, F1B);
    add_v(0, 3'b010, 3'b010, 0, F1B);
    add_v(0, 3'b000, 3'b010, 0, F1B);
    for (int i = 0; i < 3; i++) add_v(0, 3'b000, 3'b010, 0, F1B);
    add_v(0, 3'b010, 3'b010, 0, F1B);
    add_v(0, 3'b000, 3'b010, 0, F1B);
    add_v(0, 3'b000, 3'b010, 0, F1B);
    add_v(0, 3'b000, 3'b000, 0, BL);
    for (int i = 0; i < 3; i++) add_v(0, 3'b001, 3'b000, 0, BL);
    add_v(0, 3'b001, 3'b001, 0, F0B);
    // Owner drop together with a higher request, then chained preemption.
    add_v(0, 3'b010, 3'b010, 1, F1B);
    add_v(0, 3'b110, 3'b100, 1, F2);
    add_v(0, 3'b100, 3'b100, 0, F2);
    add_v(0, 3'b100, 3'b100, 0, F2);
    add_v(1, 3'b100, 3'b000, 0, BL);
    // Simultaneous new requests from IDLE: highest wins.
    add_v(0, 3'b111, 3'b100, 0, F2);
    add_v(1, 3'b111, 3'b000, 0, BL);
    add_v(0, 3'b011, 3'b010, 0, F1B);
    add_v(1, 3'b000, 3'b000, 0, BL);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].f0, vecs[i].f1, vecs[i].f2,
            {vecs[i].eg, vecs[i].ep, vecs[i].egl});
      score($sformatf("vec%0d", i));
    end

    // Measured hold and gap lengths after a one-cycle request.
    rst = 1'b1; req = 3'b000; tick();
    rst = 1'b0; req = 3'b010; frame1 = F1; tick();
    req = 3'b001;
    cnt = 0;
    while (grant == 3'b010 && cnt < 50) begin cnt++; tick(); end
    check_int("hold_len", cnt, MIN_HOLD + 1);
    gap_len = 0;
    while (grant == 3'b000 && disp_glyphs == BL && gap_len < 50) begin gap_len++; tick(); end
    check_int("gap_len", gap_len, GAP_CYCLES);
    check_out("after_gap", {3'b001, 1'b0, frame0});

    // Error owner held: blinking (if enabled), then reset mid-blink.
    drive(1, 3'b000, F0, F1, F2, {3'b000, 1'b0, BL});
    score("blink_rst0");
    for (int k = 0; k < 5; k++) begin
      exp_gl = (BLINK && ((k / BLINK_HALF) % 2 == 1)) ? BL : F2;
      drive(0, 3'b100, F0, F1, F2, {3'b100, 1'b0, exp_gl});
      score($sformatf("blink%0d", k));
    end
    drive(1, 3'b100, F0, F1, F2, {3'b000, 1'b0, BL});
    score("blink_rst1");

    // Random frames must follow the owner one cycle later.
    for (int k = 0; k < 12; k++) begin
      rnd = {$urandom(), $urandom()};
      drive(0, 3'b001, rnd[39:0], F1, F2, {3'b001, 1'b0, rnd[39:0]});
      score($sformatf("rand%0d", k));
    end
    rst = 1'b1; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
